// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: run-time baud-rate reconfiguration for uart_clk_gen.
// Stalls TxD/RxD, drains traffic, resets clkgen with the new select, settles.
//
// Ports:
//   ref_clk_i       reference clock (shared with uart_clk_gen)
//   rst             asynchronous reset, active-high
//   cfg_req_i       reconfiguration request level, held until cfg_ack_o
//   cfg_baud_sel_i  requested one-hot baud select, sampled at acceptance
//   cfg_ack_o       one-cycle completion pulse
//   cfg_err_o       qualifies cfg_ack_o: 1 = rejected or drain timed out
//   tx_busy_i       TxD frame in progress
//   rx_busy_i       RxD frame in progress
//   uart_hold_o     no new TxD/RxD frame may start
//   baudrate_sel_o  select driven to uart_clk_gen
//   clkgen_rstn_o   active-low reset to uart_clk_gen
//   ctrl_busy_o     controller not idle
module uart_baud_ctrl #(
    parameter int               SEL_W         = 7,
    parameter logic [SEL_W-1:0] DEFAULT_SEL   = SEL_W'(2),
    parameter int               DRAIN_TIMEOUT = 1_000_000,
    parameter int               RST_CYCLES    = 4,
    parameter int               SETTLE_CYCLES = 16
) (
    input  logic             ref_clk_i,
    input  logic             rst,
    input  logic             cfg_req_i,
    input  logic [SEL_W-1:0] cfg_baud_sel_i,
    output logic             cfg_ack_o,
    output logic             cfg_err_o,
    input  logic             tx_busy_i,
    input  logic             rx_busy_i,
    output logic             uart_hold_o,
    output logic [SEL_W-1:0] baudrate_sel_o,
    output logic             clkgen_rstn_o,
    output logic             ctrl_busy_o
);

    localparam int MAX_A = (DRAIN_TIMEOUT > RST_CYCLES)
                         ? DRAIN_TIMEOUT : RST_CYCLES;
    localparam int MAX_C = (MAX_A > SETTLE_CYCLES)
                         ? MAX_A : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_DRAIN,
        S_APPLY,
        S_SETTLE,
        S_ACK
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] sel_q;
    logic             armed_q;
    logic             from_init_q;
    logic             accept;
    logic             err_nxt;
    logic             one_hot;

    assign one_hot = (cfg_baud_sel_i != '0) &&
                     ((cfg_baud_sel_i & (cfg_baud_sel_i - 1'b1)) == '0);

    always_comb begin
        state_nxt = state_q;
        err_nxt   = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            S_INIT: begin
                if (cnt_q == RST_LAST)
                    state_nxt = S_SETTLE;
            end
            S_IDLE: begin
                if (cfg_req_i && armed_q) begin
                    accept = 1'b1;
                    if (!one_hot) begin
                        state_nxt = S_ACK;
                        err_nxt   = 1'b1;
                    end else if (cfg_baud_sel_i == baudrate_sel_o) begin
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Only a cycle with both lines idle counts as drained;
                // the timeout keeps running across busy toggles.
                if (!tx_busy_i && !rx_busy_i) begin
                    state_nxt = S_APPLY;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_nxt = S_ACK;
                    err_nxt   = 1'b1;
                end
            end
            S_APPLY: begin
                if (cnt_q == RST_LAST)
                    state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST)
                    state_nxt = from_init_q ? S_IDLE : S_ACK;
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with
    // the state they describe without any input->output path.
    always_ff @(posedge ref_clk_i or posedge rst) begin
        if (rst) begin
            state_q        <= S_INIT;
            cnt_q          <= '0;
            sel_q          <= DEFAULT_SEL;
            armed_q        <= 1'b1;
            from_init_q    <= 1'b1;
            baudrate_sel_o <= DEFAULT_SEL;
            clkgen_rstn_o  <= 1'b0;
            uart_hold_o    <= 1'b1;
            cfg_ack_o      <= 1'b0;
            cfg_err_o      <= 1'b0;
            ctrl_busy_o    <= 1'b1;
        end else begin
            state_q <= state_nxt;

            if (state_nxt != state_q)
                cnt_q <= '0;
            else if (cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;

            // Re-arm only after req is seen low, so one request
            // produces exactly one ack.
            if (state_q == S_IDLE) begin
                if (!cfg_req_i)
                    armed_q <= 1'b1;
                else if (accept)
                    armed_q <= 1'b0;
            end

            if (accept)
                sel_q <= cfg_baud_sel_i;

            if (state_q == S_INIT)
                from_init_q <= 1'b1;
            else if (state_q == S_DRAIN)
                from_init_q <= 1'b0;

            if (state_nxt == S_APPLY && state_q != S_APPLY)
                baudrate_sel_o <= sel_q;

            clkgen_rstn_o <= !(state_nxt == S_INIT ||
                               state_nxt == S_APPLY);
            uart_hold_o   <= !(state_nxt == S_IDLE ||
                               state_nxt == S_ACK);
            cfg_ack_o     <= (state_nxt == S_ACK);
            cfg_err_o     <= (state_nxt == S_ACK) && err_nxt;
            ctrl_busy_o   <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb_uart_baud_ctrl: directed bench for uart_baud_ctrl.
// Cycle k = k-th clock period after the accept (or reset release) edge.
module tb_uart_baud_ctrl;

    localparam int SEL_W = 7;
    localparam logic [SEL_W-1:0] DEF = 7'b000_0010;

    logic             ref_clk_i = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_req_i = 1'b0;
    logic [SEL_W-1:0] cfg_baud_sel_i = '0;
    logic             cfg_ack_o;
    logic             cfg_err_o;
    logic             tx_busy_i = 1'b0;
    logic             rx_busy_i = 1'b0;
    logic             uart_hold_o;
    logic [SEL_W-1:0] baudrate_sel_o;
    logic             clkgen_rstn_o;
    logic             ctrl_busy_o;

    int checks = 0;
    int errors = 0;

    always #5 ref_clk_i = ~ref_clk_i;

    uart_baud_ctrl #(
        .SEL_W        (SEL_W),
        .DEFAULT_SEL  (DEF),
        .DRAIN_TIMEOUT(100),
        .RST_CYCLES   (4),
        .SETTLE_CYCLES(16)
    ) dut (
        .ref_clk_i     (ref_clk_i),
        .rst           (rst),
        .cfg_req_i     (cfg_req_i),
        .cfg_baud_sel_i(cfg_baud_sel_i),
        .cfg_ack_o     (cfg_ack_o),
        .cfg_err_o     (cfg_err_o),
        .tx_busy_i     (tx_busy_i),
        .rx_busy_i     (rx_busy_i),
        .uart_hold_o   (uart_hold_o),
        .baudrate_sel_o(baudrate_sel_o),
        .clkgen_rstn_o (clkgen_rstn_o),
        .ctrl_busy_o   (ctrl_busy_o)
    );

    task automatic test_reset();
        int rst_lo;
        int hold_lo_cyc;
        int n_ack;
        rst_lo = 0; hold_lo_cyc = -1; n_ack = 0;
        rst = 1'b1;
        @(negedge ref_clk_i);
        checks++;
        if ({baudrate_sel_o, clkgen_rstn_o, uart_hold_o, cfg_ack_o,
             cfg_err_o, ctrl_busy_o} !== {DEF, 5'b01001}) begin
            errors++;
            $display("FAIL reset_vals: sel=%b rstn=%b hold=%b ack=%b err=%b busy=%b",
                     baudrate_sel_o, clkgen_rstn_o, uart_hold_o,
                     cfg_ack_o, cfg_err_o, ctrl_busy_o);
        end
        rst = 1'b0;
        #1;
        for (int k = 1; k <= 25; k++) begin
            if (!clkgen_rstn_o) rst_lo++;
            if (hold_lo_cyc < 0 && !uart_hold_o) hold_lo_cyc = k;
            if (cfg_ack_o) n_ack++;
            @(negedge ref_clk_i);
        end
        checks++;
        if (rst_lo !== 4) begin
            errors++;
            $display("FAIL init_rstn_low: got %0d want 4", rst_lo);
        end
        checks++;
        if (hold_lo_cyc !== 21) begin
            errors++;
            $display("FAIL init_hold_release: got %0d want 21", hold_lo_cyc);
        end
        checks++;
        if (n_ack !== 0 || baudrate_sel_o !== DEF || ctrl_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL init_end: acks=%0d sel=%b busy=%b want 0 %b 0",
                     n_ack, baudrate_sel_o, ctrl_busy_o, DEF);
        end
    endtask

    task automatic test_reconfig();
        int ack_cyc;
        int n_ack;
        int rst_lo;
        int sel_cyc;
        logic err_at;
        logic hold1;
        ack_cyc = -1; n_ack = 0; rst_lo = 0; sel_cyc = -1; err_at = 1'b1;
        cfg_baud_sel_i = 7'b000_1000;
        cfg_req_i = 1'b1;
        @(negedge ref_clk_i);
        hold1 = uart_hold_o;
        for (int k = 1; k <= 30; k++) begin
            if (cfg_ack_o) begin
                n_ack++; ack_cyc = k; err_at = cfg_err_o; cfg_req_i = 1'b0;
            end
            if (!clkgen_rstn_o) rst_lo++;
            if (sel_cyc < 0 && baudrate_sel_o == 7'b000_1000) sel_cyc = k;
            @(negedge ref_clk_i);
        end
        checks++;
        if (ack_cyc !== 22 || n_ack !== 1 || err_at !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ack: cyc=%0d n=%0d err=%b want 22 1 0",
                     ack_cyc, n_ack, err_at);
        end
        checks++;
        if (rst_lo !== 4 || sel_cyc !== 2) begin
            errors++;
            $display("FAIL cfg_apply: rstn_low=%0d sel_cyc=%0d want 4 2",
                     rst_lo, sel_cyc);
        end
        checks++;
        if (hold1 !== 1'b1 || uart_hold_o !== 1'b0) begin
            errors++;
            $display("FAIL cfg_hold: drain=%b end=%b want 1 0", hold1, uart_hold_o);
        end
    endtask

    task automatic test_invalid();
        int ack_cyc;
        int hold_hi;
        logic err_at;
        ack_cyc = -1; hold_hi = 0; err_at = 1'b0;
        cfg_baud_sel_i = 7'b000_0110;
        cfg_req_i = 1'b1;
        @(negedge ref_clk_i);
        for (int k = 1; k <= 6; k++) begin
            if (cfg_ack_o) begin
                ack_cyc = k; err_at = cfg_err_o; cfg_req_i = 1'b0;
            end
            if (uart_hold_o) hold_hi++;
            @(negedge ref_clk_i);
        end
        checks++;
        if (ack_cyc !== 1 || err_at !== 1'b1) begin
            errors++;
            $display("FAIL inval_ack: cyc=%0d err=%b want 1 1", ack_cyc, err_at);
        end
        checks++;
        if (hold_hi !== 0 || baudrate_sel_o !== 7'b000_1000) begin
            errors++;
            $display("FAIL inval_side: hold_cyc=%0d sel=%b want 0 0001000",
                     hold_hi, baudrate_sel_o);
        end
    endtask

    task automatic test_timeout();
        int ack_cyc;
        int hold_hi;
        int rst_lo;
        logic err_at;
        ack_cyc = -1; hold_hi = 0; rst_lo = 0; err_at = 1'b0;
        tx_busy_i = 1'b1;
        cfg_baud_sel_i = 7'b010_0000;
        cfg_req_i = 1'b1;
        @(negedge ref_clk_i);
        for (int k = 1; k <= 110; k++) begin
            if (cfg_ack_o) begin
                ack_cyc = k; err_at = cfg_err_o; cfg_req_i = 1'b0;
            end
            if (uart_hold_o) hold_hi++;
            if (!clkgen_rstn_o) rst_lo++;
            // rx toggling must not advance or reset the drain
            rx_busy_i = k[0];
            @(negedge ref_clk_i);
        end
        tx_busy_i = 1'b0;
        rx_busy_i = 1'b0;
        checks++;
        if (ack_cyc !== 101 || err_at !== 1'b1) begin
            errors++;
            $display("FAIL tmo_ack: cyc=%0d err=%b want 101 1", ack_cyc, err_at);
        end
        checks++;
        if (hold_hi !== 100 || rst_lo !== 0 || baudrate_sel_o !== 7'b000_1000) begin
            errors++;
            $display("FAIL tmo_side: hold=%0d rstn_low=%0d sel=%b want 100 0 0001000",
                     hold_hi, rst_lo, baudrate_sel_o);
        end
    endtask

    task automatic test_one_ack();
        int n_ack;
        int ack_cyc;
        logic err_at;
        n_ack = 0; ack_cyc = -1; err_at = 1'b1;
        cfg_baud_sel_i = 7'b000_0001;
        cfg_req_i = 1'b1;
        @(negedge ref_clk_i);
        for (int k = 1; k <= 72; k++) begin
            if (cfg_ack_o) begin
                n_ack++; ack_cyc = k;
            end
            @(negedge ref_clk_i);
        end
        checks++;
        if (n_ack !== 1 || ack_cyc !== 22 || ctrl_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL held_req: acks=%0d cyc=%0d busy=%b want 1 22 0",
                     n_ack, ack_cyc, ctrl_busy_o);
        end
        cfg_req_i = 1'b0;
        @(negedge ref_clk_i);
        @(negedge ref_clk_i);
        cfg_req_i = 1'b1;
        @(negedge ref_clk_i);
        ack_cyc = -1;
        for (int k = 1; k <= 4; k++) begin
            if (cfg_ack_o) begin
                ack_cyc = k; err_at = cfg_err_o; cfg_req_i = 1'b0;
            end
            @(negedge ref_clk_i);
        end
        checks++;
        if (ack_cyc !== 1 || err_at !== 1'b0 || baudrate_sel_o !== 7'b000_0001) begin
            errors++;
            $display("FAIL rearm: cyc=%0d err=%b sel=%b want 1 0 0000001",
                     ack_cyc, err_at, baudrate_sel_o);
        end
    endtask

    task automatic test_rst_mid();
        int n_ack;
        int rst_lo;
        int hold_lo_cyc;
        n_ack = 0; rst_lo = 0; hold_lo_cyc = -1;
        cfg_baud_sel_i = 7'b000_0100;
        cfg_req_i = 1'b1;
        @(negedge ref_clk_i);
        for (int k = 1; k < 10; k++) begin
            if (cfg_ack_o) n_ack++;
            @(negedge ref_clk_i);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({baudrate_sel_o, clkgen_rstn_o, uart_hold_o, cfg_ack_o,
             ctrl_busy_o} !== {DEF, 4'b0101}) begin
            errors++;
            $display("FAIL midrst_vals: sel=%b rstn=%b hold=%b ack=%b busy=%b",
                     baudrate_sel_o, clkgen_rstn_o, uart_hold_o,
                     cfg_ack_o, ctrl_busy_o);
        end
        @(negedge ref_clk_i);
        cfg_req_i = 1'b0;
        rst = 1'b0;
        #1;
        for (int k = 1; k <= 25; k++) begin
            if (!clkgen_rstn_o) rst_lo++;
            if (hold_lo_cyc < 0 && !uart_hold_o) hold_lo_cyc = k;
            if (cfg_ack_o) n_ack++;
            @(negedge ref_clk_i);
        end
        checks++;
        if (n_ack !== 0 || rst_lo !== 4 || hold_lo_cyc !== 21) begin
            errors++;
            $display("FAIL midrst_init: acks=%0d rstn_low=%0d hold_cyc=%0d want 0 4 21",
                     n_ack, rst_lo, hold_lo_cyc);
        end
        checks++;
        if (baudrate_sel_o !== DEF) begin
            errors++;
            $display("FAIL midrst_sel: got %b want %b", baudrate_sel_o, DEF);
        end
    endtask

    initial begin
        test_reset();
        test_reconfig();
        test_invalid();
        test_timeout();
        test_one_ack();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
